// File: rtl/axi4_master_bridge_if.sv
// ---------------------------------------------------------------------------
// axi4_master_bridge_if
// Purpose : bundles the simple request/response port and the five AXI4
//           channels (AW, W, B, AR, R) used by axi4_master_bridge.
// Modports:
//   master - the bridge side: accepts requests, emits responses, drives the
//            AXI4 master outputs and samples the AXI4 slave responses.
//   slave  - the environment side (requester + AXI4 slave).
//
// Handshake rule on every valid/ready pair: a transfer happens on a rising
// clock edge where both valid and ready are 1; the valid side holds its
// payload stable until that edge. resp_valid has no ready and is a
// one-cycle pulse that the consumer must take.
// ---------------------------------------------------------------------------
interface axi4_master_bridge_if;
    // request / response
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [7:0]  req_len;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        resp_err;
    // AW
    logic        awready;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    // W
    logic        wready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    // B
    logic        bready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    // AR
    logic        arready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    // R
    logic        rready;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, req_len,
        output req_ready, resp_valid, resp_data, resp_last, resp_err,
        input  awready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wready,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        input  bvalid, bresp, bid,
        input  arready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,
        input  rvalid, rresp, rdata, rlast, rid
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, req_len,
        input  req_ready, resp_valid, resp_data, resp_last, resp_err,
        output awready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output wready,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        output bvalid, bresp, bid,
        output arready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,
        output rvalid, rresp, rdata, rlast, rid
    );
endinterface

// File: rtl/axi4_master_bridge.sv
// ---------------------------------------------------------------------------
// axi4_master_bridge
// Purpose : converts single requests (one write beat or one read burst) into
//           AXI4 master transactions, one transaction outstanding at a time.
// Ports   :
//   i_clk        - sole clock, all state on the rising edge
//   i_rst_n      - asynchronous active-low reset; aborts any transaction
//   m_if         - axi4_master_bridge_if.master (request/response + AXI4)
//   o_dbg_state  - current FSM state (0 IDLE, 1 RADDR, 2 RDATA, 3 WADDR,
//                  4 WRESP)
// Parameter:
//   AXI_ID       - constant ID driven on awid/arid
// Configuration macro:
//   AXIM_BURST_EN - when defined, reads are bursts of req_len+1 beats;
//                   otherwise req_len is ignored and every read is one beat.
//
// Every output is a flop (or a constant); the output process below only
// computes the next values, so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module axi4_master_bridge #(
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    axi4_master_bridge_if.master        m_if,
    output logic [2:0]                  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WADDR = 3'd3,
        S_WRESP = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // latched request
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [7:0]  r_count;

    // registered outputs
    logic        r_req_ready;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic        r_resp_last;
    logic        r_resp_err;

    // next values of the registered outputs
    logic        w_req_ready_nxt;
    logic        w_arvalid_nxt;
    logic        w_rready_nxt;
    logic        w_awvalid_nxt;
    logic        w_wvalid_nxt;
    logic        w_bready_nxt;
    logic        w_resp_valid_nxt;
    logic [31:0] w_resp_data_nxt;
    logic        w_resp_last_nxt;
    logic        w_resp_err_nxt;

    logic        w_req_fire;
    logic        w_ar_fire;
    logic        w_r_fire;
    logic        w_aw_fire;
    logic        w_w_fire;
    logic        w_b_fire;
    logic        w_aw_done;
    logic        w_w_done;
    logic        w_last_beat;
    logic [7:0]  w_len_eff;
    logic        w_unused_ok;

`ifdef AXIM_BURST_EN
    logic [7:0]  r_len;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len <= 8'd0;
        end else if (w_req_fire) begin
            r_len <= m_if.req_len;
        end
    end

    assign w_len_eff   = r_len;
    assign w_unused_ok = ^{m_if.bid, m_if.rid, m_if.bresp[0], m_if.rresp[0]};
`else
    // Single-beat reads: the requested length is dropped on the floor.
    assign w_len_eff   = 8'd0;
    assign w_unused_ok = ^{m_if.bid, m_if.rid, m_if.bresp[0], m_if.rresp[0],
                           m_if.req_len};
`endif

    assign w_req_fire  = m_if.req_valid & r_req_ready;
    assign w_ar_fire   = r_arvalid & m_if.arready;
    assign w_r_fire    = r_rready  & m_if.rvalid;
    assign w_aw_fire   = r_awvalid & m_if.awready;
    assign w_w_fire    = r_wvalid  & m_if.wready;
    assign w_b_fire    = r_bready  & m_if.bvalid;
    // A channel counts as done if it finished earlier or finishes this edge.
    assign w_aw_done   = ~r_awvalid | m_if.awready;
    assign w_w_done    = ~r_wvalid  | m_if.wready;
    // The burst length is ours, not the slave's: rlast only flags errors.
    assign w_last_beat = (r_count == w_len_eff);

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req_fire) w_state_nxt = m_if.req_write ? S_WADDR : S_RADDR;
            S_RADDR: if (w_ar_fire) w_state_nxt = S_RDATA;
            S_RDATA: if (w_r_fire && w_last_beat) w_state_nxt = S_IDLE;
            S_WADDR: if (w_aw_done && w_w_done) w_state_nxt = S_WRESP;
            S_WRESP: if (w_b_fire) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output logic (next values) ----------------
    always_comb begin
        w_req_ready_nxt  = (w_state_nxt == S_IDLE);
        w_arvalid_nxt    = (w_state_nxt == S_RADDR);
        w_rready_nxt     = (w_state_nxt == S_RDATA);
        w_bready_nxt     = (w_state_nxt == S_WRESP);
        w_awvalid_nxt    = r_awvalid;
        w_wvalid_nxt     = r_wvalid;
        w_resp_valid_nxt = 1'b0;
        w_resp_data_nxt  = 32'd0;
        w_resp_last_nxt  = 1'b0;
        w_resp_err_nxt   = 1'b0;

        // AW and W start together and retire independently.
        if (w_req_fire && m_if.req_write) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
        end else begin
            if (w_aw_fire) w_awvalid_nxt = 1'b0;
            if (w_w_fire)  w_wvalid_nxt  = 1'b0;
        end

        if (w_r_fire) begin
            w_resp_valid_nxt = 1'b1;
            w_resp_data_nxt  = m_if.rdata;
            w_resp_last_nxt  = w_last_beat;
            w_resp_err_nxt   = m_if.rresp[1] | (m_if.rlast != w_last_beat);
        end else if (w_b_fire) begin
            w_resp_valid_nxt = 1'b1;
            w_resp_last_nxt  = 1'b1;
            w_resp_err_nxt   = m_if.bresp[1];
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_ready  <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
            r_resp_last  <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_req_ready  <= w_req_ready_nxt;
            r_arvalid    <= w_arvalid_nxt;
            r_rready     <= w_rready_nxt;
            r_awvalid    <= w_awvalid_nxt;
            r_wvalid     <= w_wvalid_nxt;
            r_bready     <= w_bready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_data  <= w_resp_data_nxt;
            r_resp_last  <= w_resp_last_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    // ---------------- request latch and beat counter ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
            r_count <= 8'd0;
        end else if (w_req_fire) begin
            r_addr  <= m_if.req_addr;
            r_wdata <= m_if.req_wdata;
            r_wstrb <= m_if.req_wstrb;
            r_count <= 8'd0;
        end else if (w_r_fire) begin
            r_count <= r_count + 8'd1;
        end
    end

    // ---------------- port assignments ----------------
    assign m_if.req_ready  = r_req_ready;
    assign m_if.resp_valid = r_resp_valid;
    assign m_if.resp_data  = r_resp_data;
    assign m_if.resp_last  = r_resp_last;
    assign m_if.resp_err   = r_resp_err;

    assign m_if.awvalid    = r_awvalid;
    assign m_if.awaddr     = r_addr;
    assign m_if.awid       = AXI_ID;
    assign m_if.awlen      = 8'd0;
    assign m_if.awsize     = 3'b010;
    assign m_if.awburst    = 2'b01;

    assign m_if.wvalid     = r_wvalid;
    assign m_if.wdata      = r_wdata;
    assign m_if.wstrb      = r_wstrb;
    assign m_if.wlast      = 1'b1;

    assign m_if.bready     = r_bready;

    assign m_if.arvalid    = r_arvalid;
    assign m_if.araddr     = r_addr;
    assign m_if.arid       = AXI_ID;
    assign m_if.arlen      = w_len_eff;
    assign m_if.arsize     = 3'b010;
    assign m_if.arburst    = 2'b01;

    assign m_if.rready     = r_rready;

    assign o_dbg_state     = r_state;

endmodule
